// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the bus enable arbiter.
// Defines the FSM state type, the default widths and a one-hot encoder.
package bus_arb_pkg;

    typedef enum logic [1:0] {IDLE, BURST, GAP} arb_state_t;

    localparam int unsigned DEF_N  = 4;
    localparam int unsigned DEF_LW = 4;
    localparam int unsigned DEF_DW = 8;
    localparam int unsigned MAX_N  = 32;

    // Callers narrow the result to their own requester count with a size cast.
    function automatic logic [MAX_N-1:0] onehot(input int unsigned idx);
        return MAX_N'(1) << idx;
    endfunction

endpackage

// File: rtl/bus_enable_arbiter_if.sv
// Request/grant/bus signals between N requesters and the enable arbiter.
// The slave modport is the arbiter's view; master is the requester/bus side.
interface bus_enable_arbiter_if #(
    parameter int unsigned N  = 4,
    parameter int unsigned LW = 4,
    parameter int unsigned DW = 8
) ();

    logic [N-1:0]    req;
    logic [N*LW-1:0] len;
    logic [N-1:0]    grant;
    logic            enable;
    logic [DW-1:0]   data_in;
    logic [N-1:0]    done;
    logic [DW-1:0]   done_data;

    modport slave (
        input  req,
        input  len,
        input  data_in,
        output grant,
        output enable,
        output done,
        output done_data
    );

    modport master (
        output req,
        output len,
        output data_in,
        input  grant,
        input  enable,
        input  done,
        input  done_data
    );

endinterface

// File: rtl/bus_enable_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i,
// wrapping N-1 -> 0, found by scanning a masked double-width copy of req_i.
module rr_pick
    import bus_arb_pkg::*;
#(
    parameter int unsigned N = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic          valid_o,
    output logic [IW-1:0] idx_o,
    output logic [N-1:0]  onehot_o
);

    localparam logic [2*N-1:0] ONE_W = {{(2*N-1){1'b0}}, 1'b1};

    logic [2*N-1:0] dbl;
    logic [2*N-1:0] below_ptr;
    logic [2*N-1:0] masked;
    logic           found;

    // The upper copy is unmasked, so any set request is always reached.
    assign dbl       = {req_i, req_i};
    assign below_ptr = (ONE_W << ptr_i) - ONE_W;
    assign masked    = dbl & ~below_ptr;
    assign valid_o   = |req_i;

    always_comb begin
        found = 1'b0;
        idx_o = '0;
        for (int unsigned i = 0; i < 2 * N; i++) begin
            if (!found && masked[i]) begin
                found = 1'b1;
                idx_o = IW'(i % N);
            end
        end
    end

    always_comb begin
        onehot_o = '0;
        if (valid_o) begin
            onehot_o = N'(onehot(32'(idx_o)));
        end
    end

endmodule

// File: rtl/bus_enable_arbiter.sv
// Shares one bus enable line between N requesters: non-preemptive round-robin
// bursts of latched length, one gap cycle, then a done pulse with the bus count.
module bus_enable_arbiter
    import bus_arb_pkg::*;
#(
    parameter int unsigned N  = DEF_N,
    parameter int unsigned LW = DEF_LW,
    parameter int unsigned DW = DEF_DW
) (
    input  logic                 clk,
    input  logic                 rst,
    bus_enable_arbiter_if.slave  bus
);

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    arb_state_t    state_q, state_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [N-1:0]  done_q, done_d;
    logic          enable_q, enable_d;
    logic [DW-1:0] done_data_q, done_data_d;

    logic          pick_valid;
    logic [IW-1:0] pick_idx;
    logic [N-1:0]  pick_oh;
    logic [LW-1:0] win_len;

    rr_pick #(.N(N)) u_pick (
        .req_i    (bus.req),
        .ptr_i    (ptr_q),
        .valid_o  (pick_valid),
        .idx_o    (pick_idx),
        .onehot_o (pick_oh)
    );

    assign win_len = bus.len[32'(pick_idx) * LW +: LW];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        enable_d    = enable_q;
        done_d      = '0;
        done_data_d = done_data_q;

        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d  = pick_oh;
                    enable_d = 1'b1;
                    // A zero length still yields one enable cycle.
                    cnt_d    = (win_len == '0) ? '0 : win_len - 1'b1;
                    ptr_d    = (pick_idx == IW'(N - 1)) ? '0 : pick_idx + 1'b1;
                    state_d  = BURST;
                end
            end
            BURST: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    enable_d = 1'b0;
                    state_d  = GAP;
                end
            end
            GAP: begin
                done_d      = grant_q;
                done_data_d = bus.data_in;
                grant_d     = '0;
                state_d     = IDLE;
            end
            default: begin
                state_d  = IDLE;
                grant_d  = '0;
                enable_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ptr_q       <= '0;
            grant_q     <= '0;
            enable_q    <= 1'b0;
            done_q      <= '0;
            done_data_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            enable_q    <= enable_d;
            done_q      <= done_d;
            done_data_q <= done_data_d;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.enable    = enable_q;
    assign bus.done      = done_q;
    assign bus.done_data = done_data_q;

    a_grant_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(grant_q));
    a_done_onehot0:  assert property (@(posedge clk) disable iff (rst) $onehot0(done_q));
    a_enable_owned:  assert property (@(posedge clk) disable iff (rst) enable_q |-> (grant_q != '0));

endmodule

// File: tb/tb_bus_enable_arbiter.sv
// Bench for bus_enable_arbiter beside a counting bus model, checked every cycle
// against a burst-level reference model plus directed literal expectations.
module tb_bus_enable_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned LW = 4;
    localparam int unsigned DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [DW-1:0] bus_data = '0;

    int n_chk = 0;
    int n_err = 0;

    bus_enable_arbiter_if #(.N(N), .LW(LW), .DW(DW)) bus ();

    bus_enable_arbiter #(.N(N), .LW(LW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // myBus stand-in: clears while disabled, counts enabled edges.
    always @(posedge clk or posedge rst) begin
        if (rst) bus_data <= '0;
        else     bus_data <= bus.enable ? bus_data + 1'b1 : '0;
    end
    assign bus.data_in = bus_data;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: one owner at a time, k counts cycles since its grant edge.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_k     = 0;
    int m_L     = 0;
    logic [N-1:0]  m_done = '0;
    logic [DW-1:0] m_dd   = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner = -1; m_ptr = 0; m_k = 0; m_L = 0; m_done = '0; m_dd = '0;
        end else begin
            m_done = '0;
            if (m_owner < 0) begin
                if (bus.req != '0) begin
                    for (int j = 0; j < N; j++) begin
                        int w;
                        w = (m_ptr + j) % N;
                        if (m_owner < 0 && bus.req[w]) m_owner = w;
                    end
                    m_L   = int'(bus.len[m_owner*LW +: LW]);
                    if (m_L == 0) m_L = 1;
                    m_k   = 1;
                    m_ptr = (m_owner + 1) % N;
                end
            end else begin
                m_k++;
                if (m_k == m_L + 2) begin
                    m_done  = N'(1) << m_owner;
                    m_dd    = DW'(m_L);
                    m_owner = -1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            logic [N-1:0] eg;
            logic         ee;
            eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
            ee = (m_owner >= 0) && (m_k <= m_L);
            chk("model_grant", bus.grant, eg);
            chk("model_enable", bus.enable, ee);
            chk("model_done", bus.done, m_done);
            if (m_done != '0) chk("model_done_data", bus.done_data, m_dd);
        end
    end

    task automatic do_reset();
        @(negedge clk) rst = 1'b1;
        bus.req = '0;
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic wait_grant(output bit ok);
        ok = 0;
        for (int c = 0; c < 12 && !ok; c++) begin
            @(negedge clk);
            if (bus.grant != '0) ok = 1;
        end
        if (!ok) chk("grant_timeout", 0, 1);
    endtask

    task automatic do_burst(input logic [N-1:0] rq, input logic [N*LW-1:0] ln, input int drop,
                            input logic [N-1:0] exp_g, input int exp_len, input string nm);
        bit ok;
        int n;
        bus.req = rq;
        bus.len = ln;
        wait_grant(ok);
        if (!ok) return;
        chk({nm, "_grant"}, bus.grant, exp_g);
        n = 0;
        while (bus.enable === 1'b1 && n < 40) begin
            n++;
            if (n == drop) bus.req = '0;
            @(negedge clk);
        end
        chk({nm, "_gap_grant"}, bus.grant, exp_g);
        bus.req = '0;
        @(negedge clk);
        chk({nm, "_en_cycles"}, n, exp_len);
        chk({nm, "_done"}, bus.done, exp_g);
        chk({nm, "_done_data"}, bus.done_data, exp_len);
        chk({nm, "_model_dd"}, m_dd, exp_len);
    endtask

    initial begin
        bit ok;
        logic [N-1:0] order [5];
        int times [5];
        logic [N-1:0] prev;
        int got;

        bus.req = '0;
        bus.len = '0;
        repeat (2) @(negedge clk);
        chk("rst_grant", bus.grant, 0);
        chk("rst_enable", bus.enable, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_done_data", bus.done_data, 0);
        rst = 1'b0;
        @(negedge clk);

        do_burst(4'b0001, 16'h0005, 0, 4'b0001, 5, "single");
        do_burst(4'b0001, 16'h0000, 0, 4'b0001, 1, "len0");
        do_burst(4'b0001, 16'h000F, 0, 4'b0001, 15, "len15");

        do_reset();
        bus.req = 4'b1111;
        bus.len = 16'h2222;
        prev = '0;
        got  = 0;
        for (int c = 0; c < 60 && got < 5; c++) begin
            @(negedge clk);
            if (bus.grant != '0 && prev == '0) begin
                order[got] = bus.grant;
                times[got] = c;
                got++;
            end
            prev = bus.grant;
        end
        bus.req = '0;
        chk("rr_count", got, 5);
        if (got == 5) begin
            chk("rr_g0", order[0], 4'b0001);
            chk("rr_g1", order[1], 4'b0010);
            chk("rr_g2", order[2], 4'b0100);
            chk("rr_g3", order[3], 4'b1000);
            chk("rr_g4", order[4], 4'b0001);
            for (int k = 1; k < 5; k++) chk("rr_spacing", times[k] - times[k-1], 4);
        end
        repeat (6) @(negedge clk);

        do_reset();
        do_burst(4'b0001, 16'h0006, 2, 4'b0001, 6, "drop");
        do_burst(4'b0011, 16'h0011, 0, 4'b0010, 1, "ptr_adv");

        do_reset();
        bus.req = 4'b0001;
        bus.len = 16'h0008;
        wait_grant(ok);
        if (ok) begin
            @(negedge clk);
            @(negedge clk);
            #1 rst = 1'b1;
            #1;
            chk("amid_grant", bus.grant, 0);
            chk("amid_enable", bus.enable, 0);
            chk("amid_done", bus.done, 0);
            bus.req = 4'b0011;
            bus.len = 16'h1111;
            @(negedge clk) rst = 1'b0;
            wait_grant(ok);
            if (ok) begin
                chk("after_rst_grant", bus.grant, 4'b0001);
                chk("after_rst_done", bus.done, 0);
            end
        end
        bus.req = '0;
        repeat (6) @(negedge clk);

        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) bus.req = N'($urandom_range(0, 15));
            if ($urandom_range(0, 5) == 0) bus.len = (N*LW)'($urandom);
        end
        bus.req = '0;
        repeat (25) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_chk);
        $fatal(1, "watchdog expired");
    end

endmodule
